// File: rtl/div_share_arbiter.sv
// Round-robin front end sharing one signed 32/16 divider between two requesters.
// One operation in flight; divide-by-zero is screened and a missing divider response is watchdogged.
module div_share_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rq0_valid,
    output logic        rq0_ready,
    input  logic [31:0] rq0_dividend,
    input  logic [15:0] rq0_divisor,
    input  logic        rq0_mode,
    input  logic        rq1_valid,
    output logic        rq1_ready,
    input  logic [31:0] rq1_dividend,
    input  logic [15:0] rq1_divisor,
    input  logic        rq1_mode,
    output logic        rs0_valid,
    output logic [16:0] rs0_result,
    output logic        rs0_error,
    output logic        rs1_valid,
    output logic [16:0] rs1_result,
    output logic        rs1_error,
    output logic        div_valid_input,
    output logic [31:0] div_dividend,
    output logic [15:0] div_divisor,
    output logic        div_mode,
    input  logic        div_valid_output,
    input  logic [16:0] div_final_output,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic        r_prio, r_owner;
    logic [7:0]  r_cnt;
    logic [31:0] r_dvd;
    logic [15:0] r_dvs;
    logic        r_mode;
    logic        r_rs0_valid, r_rs0_error, r_rs1_valid, r_rs1_error;
    logic [16:0] r_rs0_result, r_rs1_result;

    logic        w_win, w_accept, w_load, w_load_err, w_load_owner;
    logic [16:0] w_load_res;
    logic [31:0] w_dvd;
    logic [15:0] w_dvs;
    logic        w_mode;

    // Lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        w_win = r_prio;
        if (rq0_valid && !rq1_valid)
            w_win = 1'b0;
        else if (rq1_valid && !rq0_valid)
            w_win = 1'b1;
    end

    assign w_accept  = (r_state == S_IDLE) && reset && (rq0_valid || rq1_valid);
    assign rq0_ready = w_accept && !w_win;
    assign rq1_ready = w_accept && w_win;
    assign w_dvd     = w_win ? rq1_dividend : rq0_dividend;
    assign w_dvs     = w_win ? rq1_divisor  : rq0_divisor;
    assign w_mode    = w_win ? rq1_mode     : rq0_mode;
    // A zero divisor goes straight to RESP, so the owner is still the live winner.
    assign w_load_owner = (r_state == S_IDLE) ? w_win : r_owner;

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_res = '0;
        w_load_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_dvs == 16'd0) begin
                        w_next     = S_RESP;
                        w_load     = 1'b1;
                        w_load_err = 1'b1;
                    end else begin
                        w_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (div_valid_output) begin
                    w_next     = S_RESP;
                    w_load     = 1'b1;
                    w_load_res = div_final_output;
                end else if (r_cnt == LP_LAST) begin
                    w_next     = S_RESP;
                    w_load     = 1'b1;
                    w_load_err = 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
            r_dvd        <= '0;
            r_dvs        <= '0;
            r_mode       <= 1'b0;
            r_rs0_valid  <= 1'b0;
            r_rs0_result <= '0;
            r_rs0_error  <= 1'b0;
            r_rs1_valid  <= 1'b0;
            r_rs1_result <= '0;
            r_rs1_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_dvd   <= w_dvd;
                r_dvs   <= w_dvs;
                r_mode  <= w_mode;
                r_owner <= w_win;
                r_prio  <= ~w_win;
            end
            if (r_state == S_ISSUE)
                r_cnt <= '0;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt + 8'd1;
            r_rs0_valid <= w_load && !w_load_owner;
            r_rs1_valid <= w_load && w_load_owner;
            if (w_load && !w_load_owner) begin
                r_rs0_result <= w_load_res;
                r_rs0_error  <= w_load_err;
            end
            if (w_load && w_load_owner) begin
                r_rs1_result <= w_load_res;
                r_rs1_error  <= w_load_err;
            end
        end
    end

    assign rs0_valid       = r_rs0_valid;
    assign rs0_result      = r_rs0_result;
    assign rs0_error       = r_rs0_error;
    assign rs1_valid       = r_rs1_valid;
    assign rs1_result      = r_rs1_result;
    assign rs1_error       = r_rs1_error;
    assign div_valid_input = (r_state == S_ISSUE);
    assign div_dividend    = r_dvd;
    assign div_divisor     = r_dvs;
    assign div_mode        = r_mode;
    assign busy            = (r_state != S_IDLE);
endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter; the bench itself plays the divider with a
// per-vector response latency (or none at all) and a chosen result value.
module tb_div_share_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rq0_valid = 1'b0, rq1_valid = 1'b0;
    logic        rq0_ready, rq1_ready;
    logic [31:0] rq0_dividend = '0, rq1_dividend = '0;
    logic [15:0] rq0_divisor = '0, rq1_divisor = '0;
    logic        rq0_mode = 1'b0, rq1_mode = 1'b0;
    logic        rs0_valid, rs1_valid, rs0_error, rs1_error;
    logic [16:0] rs0_result, rs1_result;
    logic        div_valid_input, div_mode, busy;
    logic [31:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_valid_output = 1'b0;
    logic [16:0] div_final_output = '0;

    int checks = 0;
    int errors = 0;

    div_share_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_dividend(rq0_dividend),
        .rq0_divisor(rq0_divisor), .rq0_mode(rq0_mode),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_dividend(rq1_dividend),
        .rq1_divisor(rq1_divisor), .rq1_mode(rq1_mode),
        .rs0_valid(rs0_valid), .rs0_result(rs0_result), .rs0_error(rs0_error),
        .rs1_valid(rs1_valid), .rs1_result(rs1_result), .rs1_error(rs1_error),
        .div_valid_input(div_valid_input), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_mode(div_mode),
        .div_valid_output(div_valid_output), .div_final_output(div_final_output),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic        md;
        int          lat;   // WAIT-cycle index of the stub response, -1 = never
        logic [16:0] sres;
        int          ecyc;  // cycles from accept edge to response
        logic [16:0] eres;
        logic        eerr;
        int          epul;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {37'd0, rq0_ready, rq1_ready, rs0_valid, rs0_result, rs0_error,
                rs1_valid, rs1_result, rs1_error, div_valid_input, div_dividend,
                div_divisor, div_mode, busy};
    endfunction

    // Called just after a negedge; returns just after a negedge one cycle past the response.
    task automatic do_op(input logic p, input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic md, input int lat, input logic [16:0] sres,
                         output int wt, output int cyc, output logic [16:0] gres,
                         output logic gerr, output int npul, output int nbad,
                         output logic opsok, output logic bsy_after);
        logic rdy;
        wt = 0; cyc = -1; gres = '0; gerr = 1'b0; npul = 0; nbad = 0; opsok = 1'b1;
        if (p) begin
            rq1_valid = 1'b1; rq1_dividend = dvd; rq1_divisor = dvs; rq1_mode = md;
        end else begin
            rq0_valid = 1'b1; rq0_dividend = dvd; rq0_divisor = dvs; rq0_mode = md;
        end
        #1;
        rdy = p ? rq1_ready : rq0_ready;
        while (!rdy && wt < 30) begin
            @(negedge clk);
            wt++;
            rdy = p ? rq1_ready : rq0_ready;
        end
        @(negedge clk);
        if (p) rq1_valid = 1'b0; else rq0_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (div_valid_input) begin
                npul++;
                if (div_dividend !== dvd || div_divisor !== dvs || div_mode !== md) opsok = 1'b0;
            end
            if ((p ? rs0_valid : rs1_valid) || (busy && (rq0_ready || rq1_ready))) nbad++;
            div_valid_output = (lat >= 0) && (c - 2 == lat);
            div_final_output = sres;
            if (p ? rs1_valid : rs0_valid) begin
                cyc  = c;
                gres = p ? rs1_result : rs0_result;
                gerr = p ? rs1_error : rs0_error;
                break;
            end
            @(negedge clk);
        end
        div_valid_output = 1'b0;
        @(negedge clk);
        bsy_after = busy;
        if (rs0_valid || rs1_valid) nbad++;
    endtask

    task automatic op_check(input string tag, input logic p, input logic [31:0] dvd,
                            input logic [15:0] dvs, input logic md, input int lat,
                            input logic [16:0] sres, input int ecyc, input logic [16:0] eres,
                            input logic eerr, input int epul, input int ewt);
        int wt, cyc, npul, nbad;
        logic [16:0] gres;
        logic gerr, opsok, ba;
        do_op(p, dvd, dvs, md, lat, sres, wt, cyc, gres, gerr, npul, nbad, opsok, ba);
        if (ewt >= 0) chk({tag, " ready_wait"}, wt, ewt);
        chk({tag, " resp_cycle"}, cyc, ecyc);
        chk({tag, " result"}, gres, eres);
        chk({tag, " error"}, gerr, eerr);
        chk({tag, " issue_pulses"}, npul, epul);
        chk({tag, " issue_operands"}, opsok, 1'b1);
        chk({tag, " stray_activity"}, nbad, 0);
        chk({tag, " busy_after"}, ba, 1'b0);
    endtask

    initial begin
        int cnt;
        vt[0] = '{1'b0, -32'sd80,     -16'sd3, 1'b1, 3,  17'd26,     6,  17'd26,     1'b0, 1};
        vt[1] = '{1'b1, 32'd1234,     16'd0,   1'b0, -1, 17'd55,     1,  17'd0,      1'b1, 0};
        vt[2] = '{1'b0, 32'd1000,     16'd10,  1'b0, -1, 17'd100,    10, 17'd0,      1'b1, 1};
        vt[3] = '{1'b1, -32'sd50,     16'd5,   1'b0, 7,  17'h1FFF6,  10, 17'h1FFF6,  1'b0, 1};
        vt[4] = '{1'b0, 32'h7FFFFFFF, 16'hFFFF, 1'b1, 0, 17'h10001,  3,  17'h10001,  1'b0, 1};
        vt[5] = '{1'b0, 32'd5,        16'd0,   1'b1, -1, 17'd9,      1,  17'd0,      1'b1, 0};

        rq0_valid = 1'b1; rq1_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs_zero", all_outs(), '0);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_outputs_zero", all_outs(), '0);

        for (int i = 0; i < 6; i++)
            op_check($sformatf("vec%0d", i), vt[i].p, vt[i].dvd, vt[i].dvs, vt[i].md,
                     vt[i].lat, vt[i].sres, vt[i].ecyc, vt[i].eres, vt[i].eerr, vt[i].epul, -1);
        chk("rs1_result_held", {rs1_result, rs1_error}, {17'h1FFF6, 1'b0});

        // Stray divider response while idle must be ignored.
        div_valid_output = 1'b1; div_final_output = 17'h155;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || rs0_valid || rs1_valid) cnt++;
        end
        div_valid_output = 1'b0;
        chk("spurious_ignored", cnt, 0);

        // Reset while waiting on the divider: dropped, no response, priority back to port 0.
        rq0_valid = 1'b1; rq0_dividend = 32'd77; rq0_divisor = 16'd9; rq0_mode = 1'b0;
        #1;
        chk("rst_mid accept_ready", rq0_ready, 1'b1);
        @(negedge clk);
        rq0_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid in_wait_busy", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid outputs_zero", all_outs(), '0);
        reset = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || rs0_valid || rs1_valid) cnt++;
        end
        chk("rst_mid no_response", cnt, 0);

        // Simultaneous pair right after reset: port 0 first, then port 1 back-to-back.
        rq0_valid = 1'b1; rq0_dividend = 32'd100; rq0_divisor = 16'd7; rq0_mode = 1'b0;
        rq1_valid = 1'b1; rq1_dividend = -32'sd50; rq1_divisor = 16'd5; rq1_mode = 1'b0;
        #1;
        chk("pairA ready", {rq0_ready, rq1_ready}, 2'b10);
        op_check("pairA_p0", 1'b0, 32'd100, 16'd7, 1'b0, 1, 17'd14, 4, 17'd14, 1'b0, 1, 0);
        op_check("pairA_p1", 1'b1, -32'sd50, 16'd5, 1'b0, 2, 17'h1FFF6, 5, 17'h1FFF6, 1'b0, 1, 0);
        op_check("single_p0", 1'b0, 32'd9, 16'd3, 1'b0, 0, 17'd3, 3, 17'd3, 1'b0, 1, 0);

        // After that lone port-0 accept, port 1 holds priority for the next tie.
        rq0_valid = 1'b1; rq0_dividend = 32'd21; rq0_divisor = 16'd4; rq0_mode = 1'b1;
        rq1_valid = 1'b1; rq1_dividend = 32'd63; rq1_divisor = 16'd8; rq1_mode = 1'b1;
        #1;
        chk("pairB ready", {rq0_ready, rq1_ready}, 2'b01);
        op_check("pairB_p1", 1'b1, 32'd63, 16'd8, 1'b1, 1, 17'h00ABC, 4, 17'h00ABC, 1'b0, 1, 0);
        op_check("pairB_p0", 1'b0, 32'd21, 16'd4, 1'b1, 4, 17'h1F0F0, 7, 17'h1F0F0, 1'b0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
